dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-side responder for the pipelined core's Memory stage. It sits at the far end of the core's address/write-data/write-enable/funct3 interface.
- Decodes each access into one of two targets: a byte-lane RAM, or a small MMIO page (LED register, 64-bit cycle counter, error status).
- Performs load sign/zero extension and store byte-lane masking, and flags misaligned or illegal accesses.
- Reads are combinational, so load data is valid in the same cycle for the core's M/W pipeline register. All state updates happen on the rising edge of clk.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words (power of two).
- MMIO_BASE, 32'h8000_0000, base address of the 16-byte MMIO page.
- LED_W, 8, width of the LED output register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  store request this cycle.
- re  input  1  load request this cycle.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned.
- funct3  input  3  access size/sign (RISC-V load/store encoding).
- rdata  output  32  extended load data (combinational).
- leds  output  LED_W  LED register.
- err  output  1  sticky access-error flag.
- err_addr  output  32  address of the first faulting access since the last clear.

Behaviour:
- Reset (synchronous): leds=0, cycle counter=0, hi shadow=0, err=0, err_addr=0. RAM contents are not cleared.
- Any we/re in a cycle with reset=1 is ignored.
- Address decode:
  - RAM hit when addr < DEPTH*4. Word index = addr[log2(DEPTH)+1:2].
  - MMIO hit when addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped: reads return 0, writes are dropped, no error.
- RAM loads (re=1, we=0), lane selected by addr[1:0]:
  - 000 LB: byte, sign-extended.
  - 100 LBU: byte, zero-extended.
  - 001 LH / 101 LHU: half selected by addr[1], sign/zero-extended.
  - 010 LW: full word.
- RAM stores (we=1), on the next rising edge:
  - SB writes one lane.
  - SH writes 2 lanes.
  - SW writes 4 lanes.
  - Unselected lanes are unchanged.
  - A store's data is not visible to rdata until the following cycle; there is no same-cycle bypass.
- Alignment and legality:
  - LH/LHU/SH need addr[0]=0. LW/SW need addr[1:0]=00.
  - Store funct3 outside {000,001,010} is illegal; load funct3 in {011,110,111} is illegal.
  - A misaligned or illegal access suppresses the write and returns rdata=0.
  - It also sets err on the next edge and captures err_addr=addr, but only if err was 0.
- MMIO accesses are word-only (funct3=010). Any other size to MMIO is treated as an error as above. Registers:
  - +0x0 LED: read/write. Write loads wdata[LED_W-1:0]; read returns it zero-extended.
  - +0x4 CNT_LO: read-only. A read with re=1 copies counter[63:32] into the hi shadow on that edge.
  - +0x8 CNT_HI: read-only. Returns the hi shadow, not the live value.
  - +0xC STATUS: read returns {31'b0, err}. Writing with wdata[0]=1 clears err and err_addr. A set and a clear in the same cycle: the clear wins.
  - Writes to CNT_LO and CNT_HI are ignored with no error.
- Cycle counter: 64-bit. Increments by 1 on every edge where reset=0. Wraps 2^64-1 -> 0.
- we and re both high: the store is performed. The re side effect (hi shadow capture) is suppressed. rdata still shows the pre-store value combinationally.
- we=re=0: rdata=0, no state change other than the counter.

Test Plan:
- Sign extension: SW 0x8001_F0FF to 0x10; then LB 0x10 -> 0xFFFF_FFFF, LBU 0x10 -> 0x0000_00FF, LH 0x12 -> 0xFFFF_8001, LHU 0x12 -> 0x0000_8001.
- Lane masking: SW 0x1122_3344 to 0x20, then SB 0xAB to 0x21. LW 0x20 -> 0x1122_AB44. SH 0xBEEF to 0x22, then LW -> 0xBEEF_AB44.
- Misalignment: SH to 0x31 -> RAM at 0x30 unchanged, err=1, err_addr=0x31. LW 0x35 -> rdata=0, err_addr still 0x31. SW 1 to MMIO+0xC -> err=0, err_addr=0.
- Counter snapshot: after reset release, hold until counter=0x1_0000_0005 (force via long run, or preload in sim). LW CNT_LO -> 0x0000_0005. Let counter advance. LW CNT_HI -> 0x0000_0001 (shadow value).
- LED and contention:
  - SW 0xA5 to MMIO+0x0 -> leds=0xA5 next cycle.
  - SB to MMIO+0x0 -> leds unchanged, err=1.
  - we=re=1 on LED -> write occurs, rdata shows old value.
- Reset mid-operation: assert reset in the same cycle as SW 0xDEAD_BEEF to 0x40 -> word 0x40 unchanged, leds=0, counter=0, err=0 on the next cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-side responder for the core's Memory stage.
//
// Every access is decoded to one of two targets:
//   - a byte-lane RAM of DEPTH 32-bit words at address 0
//   - a 16-byte MMIO page at MMIO_BASE (LED, CNT_LO, CNT_HI, STATUS)
// Anything else is unmapped. Unmapped reads return 0 and unmapped writes are
// dropped without raising an error.
// Loads are combinational. Stores and all other state change on the rising edge.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   we, re    store / load request strobes
//   addr      byte address
//   wdata     right-aligned store data
//   funct3    RISC-V load/store size and sign encoding
//   rdata     extended load data, combinational
//   leds      LED register
//   err       sticky access-error flag
//   err_addr  address of the first faulting access since the last clear
//
// Request semantics: we and re are single-cycle strobes. There is no ready or
// backpressure, so a request present at a rising edge with reset low is always
// taken at that edge. When both strobes are high, the store is performed. The
// load side still shows the pre-store value on rdata, but its side effects are
// suppressed.
module dmem_responder #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
   parameter int          LED_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             re,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic [2:0]       funct3,
   output logic [31:0]      rdata,
   output logic [LED_W-1:0] leds,
   output logic             err,
   output logic [31:0]      err_addr
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;

   logic [31:0] mem [DEPTH];
   logic [63:0] cycleCnt;
   logic [31:0] cntHiShadow;

   logic          active, ramHit, mmioHit, mapped;
   logic          f3Legal, aligned, mmioSizeOk, accessBad;
   logic [AW-1:0] wordIdx;
   logic [1:0]    regSel;
   logic [31:0]   ramWord, ramLoad, mmioLoad;
   logic [7:0]    loadByte;
   logic [15:0]   loadHalf;
   logic          ramWrite, mmioWrite, shadowLoad;
   logic [3:0]    laneMask;
   logic [31:0]   laneData;

   // Decode and legality checks.
   always_comb begin
      active  = (we | re) & ~reset;
      ramHit  = {1'b0, addr} < RAM_BYTES;
      mmioHit = addr[31:4] == MMIO_BASE[31:4];
      mapped  = ramHit | mmioHit;
      wordIdx = addr[AW+1:2];
      regSel  = addr[3:2];
      // A store uses the store encodings. Anything else uses the load encodings.
      if (we)
         f3Legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      else
         f3Legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      case (funct3[1:0])
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = addr[1:0] == 2'b00;
         default: aligned = 1'b1;
      endcase
      mmioSizeOk = ~mmioHit | (funct3 == 3'b010);
      // Unmapped accesses never fault, whatever their size or alignment.
      accessBad  = active & mapped & ~(f3Legal & aligned & mmioSizeOk);
   end

   // Load path.
   always_comb begin
      ramWord = mem[wordIdx];
      case (addr[1:0])
         2'b00:   loadByte = ramWord[7:0];
         2'b01:   loadByte = ramWord[15:8];
         2'b10:   loadByte = ramWord[23:16];
         default: loadByte = ramWord[31:24];
      endcase
      loadHalf = addr[1] ? ramWord[31:16] : ramWord[15:0];
      case (funct3)
         3'b000:  ramLoad = {{24{loadByte[7]}}, loadByte};
         3'b100:  ramLoad = {24'b0, loadByte};
         3'b001:  ramLoad = {{16{loadHalf[15]}}, loadHalf};
         3'b101:  ramLoad = {16'b0, loadHalf};
         3'b010:  ramLoad = ramWord;
         default: ramLoad = 32'b0;
      endcase
      mmioLoad = 32'b0;
      case (regSel)
         2'b00:   mmioLoad[LED_W-1:0] = leds;
         2'b01:   mmioLoad = cycleCnt[31:0];
         2'b10:   mmioLoad = cntHiShadow;
         default: mmioLoad[0] = err;
      endcase
      rdata = 32'b0;
      if (re && active && !accessBad) begin
         if (ramHit)
            rdata = ramLoad;
         else if (mmioHit)
            rdata = mmioLoad;
      end
   end

   // Store path. The data is replicated across lanes and laneMask picks the lanes to write.
   always_comb begin
      ramWrite   = we & active & ramHit & ~accessBad;
      mmioWrite  = we & active & mmioHit & ~accessBad;
      shadowLoad = re & ~we & active & mmioHit & ~accessBad & (regSel == 2'b01);
      case (funct3[1:0])
         2'b00: begin
            laneMask = 4'b0001 << addr[1:0];
            laneData = {4{wdata[7:0]}};
         end
         2'b01: begin
            laneMask = addr[1] ? 4'b1100 : 4'b0011;
            laneData = {2{wdata[15:0]}};
         end
         default: begin
            laneMask = 4'b1111;
            laneData = wdata;
         end
      endcase
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (ramWrite) begin
         for (int i = 0; i < 4; i++) begin
            if (laneMask[i])
               mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         leds        <= '0;
         cycleCnt    <= 64'd0;
         cntHiShadow <= 32'd0;
         err         <= 1'b0;
         err_addr    <= 32'd0;
      end else begin
         cycleCnt <= cycleCnt + 64'd1;
         if (accessBad && !err) begin
            err      <= 1'b1;
            err_addr <= addr;
         end
         if (shadowLoad)
            cntHiShadow <= cycleCnt[63:32];
         if (mmioWrite) begin
            case (regSel)
               2'b00: leds <= wdata[LED_W-1:0];
               2'b11: begin
                  // Placed after the set, so a clear in the same cycle wins.
                  if (wdata[0]) begin
                     err      <= 1'b0;
                     err_addr <= 32'd0;
                  end
               end
               default: ;  // counter registers are read-only
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table applied in a loop, then
// hand-written sequences for the counter snapshot and for a reset in the middle of operation.
module tb_dmem_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        we, re;
   logic [31:0] addr, wdata;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic [7:0]  leds;
   logic        err;
   logic [31:0] err_addr;

   int          nChecks = 0;
   int          nFail   = 0;
   logic [31:0] exp_q[$];
   logic [63:0] cycModel;

   typedef struct {
      string       name;
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f;
      logic [31:0] expRdata;
      logic        expErr;
      logic [31:0] expErrAddr;
      logic [7:0]  expLeds;
   } vecT;

   vecT vecs[$];

   dmem_responder dut (
      .clk      (clk),
      .reset    (reset),
      .we       (we),
      .re       (re),
      .addr     (addr),
      .wdata    (wdata),
      .funct3   (funct3),
      .rdata    (rdata),
      .leds     (leds),
      .err      (err),
      .err_addr (err_addr)
   );

   // Clock and reference cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cycModel <= 64'd0;
      else       cycModel <= cycModel + 64'd1;
   end

   // Scoreboard.
   task automatic check(input string nm, input logic [31:0] act);
      logic [31:0] e;
      nChecks++;
      if (exp_q.size() == 0) begin
         nFail++;
         $display("FAIL %s: got %h, no expected value queued", nm, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
         end
      end
   endtask

   task automatic expectEq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      exp_q.push_back(exp);
      check(nm, act);
   endtask

   // Drivers.
   task automatic drive(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
      we = w; re = r; addr = a; wdata = d; funct3 = f;
   endtask

   function automatic void add(input string nm, input logic w, input logic r,
                               input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                               input logic [31:0] er, input logic ee, input logic [31:0] eea,
                               input logic [7:0] el);
      vecT v;
      v.name = nm; v.w = w; v.r = r; v.a = a; v.d = d; v.f = f;
      v.expRdata = er; v.expErr = ee; v.expErrAddr = eea; v.expLeds = el;
      vecs.push_back(v);
   endfunction

   initial begin
      // name, we, re, addr, wdata, funct3, rdata, err, err_addr, leds (after the edge)
      add("sw_10",       1, 0, 32'h10,      32'h8001_F0FF, 3'b010, 32'h0,         0, 32'h0,  8'h00);
      add("lb_10",       0, 1, 32'h10,      32'h0,         3'b000, 32'hFFFF_FFFF, 0, 32'h0,  8'h00);
      add("lbu_10",      0, 1, 32'h10,      32'h0,         3'b100, 32'h0000_00FF, 0, 32'h0,  8'h00);
      add("lh_12",       0, 1, 32'h12,      32'h0,         3'b001, 32'hFFFF_8001, 0, 32'h0,  8'h00);
      add("lhu_12",      0, 1, 32'h12,      32'h0,         3'b101, 32'h0000_8001, 0, 32'h0,  8'h00);
      add("lw_10",       0, 1, 32'h10,      32'h0,         3'b010, 32'h8001_F0FF, 0, 32'h0,  8'h00);
      add("lbu_11",      0, 1, 32'h11,      32'h0,         3'b100, 32'h0000_00F0, 0, 32'h0,  8'h00);
      add("lb_13",       0, 1, 32'h13,      32'h0,         3'b000, 32'hFFFF_FF80, 0, 32'h0,  8'h00);
      add("sw_20",       1, 0, 32'h20,      32'h1122_3344, 3'b010, 32'h0,         0, 32'h0,  8'h00);
      add("sb_21",       1, 0, 32'h21,      32'h0000_00AB, 3'b000, 32'h0,         0, 32'h0,  8'h00);
      add("lw_20",       0, 1, 32'h20,      32'h0,         3'b010, 32'h1122_AB44, 0, 32'h0,  8'h00);
      add("sh_22",       1, 0, 32'h22,      32'h0000_BEEF, 3'b001, 32'h0,         0, 32'h0,  8'h00);
      add("lw_20b",      0, 1, 32'h20,      32'h0,         3'b010, 32'hBEEF_AB44, 0, 32'h0,  8'h00);
      add("lh_20",       0, 1, 32'h20,      32'h0,         3'b001, 32'hFFFF_AB44, 0, 32'h0,  8'h00);
      add("lbu_23",      0, 1, 32'h23,      32'h0,         3'b100, 32'h0000_00BE, 0, 32'h0,  8'h00);
      add("sw_30",       1, 0, 32'h30,      32'h5566_7788, 3'b010, 32'h0,         0, 32'h0,  8'h00);
      add("sh_31_mis",   1, 0, 32'h31,      32'h0000_1234, 3'b001, 32'h0,         1, 32'h31, 8'h00);
      add("lw_30_kept",  0, 1, 32'h30,      32'h0,         3'b010, 32'h5566_7788, 1, 32'h31, 8'h00);
      add("lw_35_mis",   0, 1, 32'h35,      32'h0,         3'b010, 32'h0,         1, 32'h31, 8'h00);
      add("rd_status",   0, 1, BASE + 12,   32'h0,         3'b010, 32'h1,         1, 32'h31, 8'h00);
      add("clr_status",  1, 0, BASE + 12,   32'h1,         3'b010, 32'h0,         0, 32'h0,  8'h00);
      add("ld_f3_011",   0, 1, 32'h10,      32'h0,         3'b011, 32'h0,         1, 32'h10, 8'h00);
      add("clr2",        1, 0, BASE + 12,   32'h1,         3'b010, 32'h0,         0, 32'h0,  8'h00);
      add("st_f3_011",   1, 0, 32'h10,      32'h0,         3'b011, 32'h0,         1, 32'h10, 8'h00);
      add("lw_10_kept",  0, 1, 32'h10,      32'h0,         3'b010, 32'h8001_F0FF, 1, 32'h10, 8'h00);
      add("st_status0",  1, 0, BASE + 12,   32'h0,         3'b010, 32'h0,         1, 32'h10, 8'h00);
      add("clr3",        1, 0, BASE + 12,   32'h1,         3'b010, 32'h0,         0, 32'h0,  8'h00);
      add("sw_led",      1, 0, BASE,        32'h0000_00A5, 3'b010, 32'h0,         0, 32'h0,  8'hA5);
      add("lw_led",      0, 1, BASE,        32'h0,         3'b010, 32'h0000_00A5, 0, 32'h0,  8'hA5);
      add("sb_led",      1, 0, BASE,        32'h0000_003C, 3'b000, 32'h0,         1, BASE,   8'hA5);
      add("lh_status",   0, 1, BASE + 12,   32'h0,         3'b001, 32'h0,         1, BASE,   8'hA5);
      add("clr4",        1, 0, BASE + 12,   32'h1,         3'b010, 32'h0,         0, 32'h0,  8'hA5);
      add("wr_rd_led",   1, 1, BASE,        32'h0000_005A, 3'b010, 32'h0000_00A5, 0, 32'h0,  8'h5A);
      add("lw_led2",     0, 1, BASE,        32'h0,         3'b010, 32'h0000_005A, 0, 32'h0,  8'h5A);
      add("lw_unmap",    0, 1, 32'h4000_0000, 32'h0,       3'b010, 32'h0,         0, 32'h0,  8'h5A);
      add("sw_unmap",    1, 0, 32'h4000_0000, 32'h1,       3'b010, 32'h0,         0, 32'h0,  8'h5A);
      add("lh_unmap_odd",0, 1, 32'h4000_0001, 32'h0,       3'b001, 32'h0,         0, 32'h0,  8'h5A);
      add("sw_cntlo",    1, 0, BASE + 4,    32'hFFFF_FFFF, 3'b010, 32'h0,         0, 32'h0,  8'h5A);
      add("idle",        0, 0, 32'h10,      32'h0,         3'b010, 32'h0,         0, 32'h0,  8'h5A);
      add("sw_40",       1, 0, 32'h40,      32'h0102_0304, 3'b010, 32'h0,         0, 32'h0,  8'h5A);
      add("swlw_40",     1, 1, 32'h40,      32'h0A0B_0C0D, 3'b010, 32'h0102_0304, 0, 32'h0,  8'h5A);
      add("lw_40",       0, 1, 32'h40,      32'h0,         3'b010, 32'h0A0B_0C0D, 0, 32'h0,  8'h5A);
      add("sw_ffc",      1, 0, 32'hFFC,     32'hCAFE_F00D, 3'b010, 32'h0,         0, 32'h0,  8'h5A);
      add("lw_ffc",      0, 1, 32'hFFC,     32'h0,         3'b010, 32'hCAFE_F00D, 0, 32'h0,  8'h5A);
      add("lw_1000",     0, 1, 32'h1000,    32'h0,         3'b010, 32'h0,         0, 32'h0,  8'h5A);

      // Reset.
      reset = 1'b1;
      drive(0, 0, 32'h0, 32'h0, 3'b000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      expectEq("rst_leds", {24'b0, leds}, 32'h0);
      expectEq("rst_err", {31'b0, err}, 32'h0);
      expectEq("rst_err_addr", err_addr, 32'h0);
      drive(0, 1, BASE + 4, 32'h0, 3'b010);
      #1 expectEq("rst_cnt_lo", rdata, 32'h0);

      // Vector table.
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].f);
         #1 expectEq({vecs[i].name, "_rdata"}, rdata, vecs[i].expRdata);
         @(posedge clk);
         #1;
         expectEq({vecs[i].name, "_err"}, {31'b0, err}, {31'b0, vecs[i].expErr});
         expectEq({vecs[i].name, "_err_addr"}, err_addr, vecs[i].expErrAddr);
         expectEq({vecs[i].name, "_leds"}, {24'b0, leds}, {24'b0, vecs[i].expLeds});
      end

      // Live counter, compared with the reference count.
      @(negedge clk);
      drive(0, 1, BASE + 4, 32'h0, 3'b010);
      #1 expectEq("cnt_lo_live", rdata, cycModel[31:0]);
      @(negedge clk);
      drive(0, 1, BASE + 8, 32'h0, 3'b010);
      #1 expectEq("cnt_hi_zero", rdata, 32'h0);

      // Hi-shadow snapshot with the counter preloaded.
      @(negedge clk);
      force dut.cycleCnt = 64'h0000_0001_0000_0005;
      drive(0, 1, BASE + 4, 32'h0, 3'b010);
      #1 expectEq("cnt_lo_5", rdata, 32'h0000_0005);
      @(negedge clk);
      force dut.cycleCnt = 64'h0000_0002_0000_0009;
      drive(0, 1, BASE + 8, 32'h0, 3'b010);
      #1 expectEq("cnt_hi_shadow", rdata, 32'h0000_0001);
      @(negedge clk);
      force dut.cycleCnt = 64'h0000_0007_0000_0000;
      drive(1, 1, BASE + 4, 32'h0, 3'b010);
      #1 expectEq("cnt_lo_wr_rd", rdata, 32'h0);
      @(negedge clk);
      drive(0, 1, BASE + 8, 32'h0, 3'b010);
      #1 expectEq("cnt_hi_no_capture", rdata, 32'h0000_0001);
      expectEq("cnt_lo_wr_err", {31'b0, err}, 32'h0);
      @(negedge clk);
      release dut.cycleCnt;
      drive(0, 0, 32'h0, 32'h0, 3'b000);

      // Reset in the middle of operation, with a store in the same cycle.
      @(negedge clk);
      drive(1, 0, BASE, 32'h0000_0011, 3'b000);
      @(negedge clk);
      expectEq("pre_rst_err", {31'b0, err}, 32'h1);
      reset = 1'b1;
      drive(1, 0, 32'h40, 32'hDEAD_BEEF, 3'b010);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 1, BASE + 4, 32'h0, 3'b010);
      #1;
      expectEq("mid_rst_cnt", rdata, 32'h0);
      expectEq("mid_rst_err", {31'b0, err}, 32'h0);
      expectEq("mid_rst_err_addr", err_addr, 32'h0);
      expectEq("mid_rst_leds", {24'b0, leds}, 32'h0);
      @(negedge clk);
      drive(0, 1, 32'h40, 32'h0, 3'b010);
      #1 expectEq("mid_rst_ram_kept", rdata, 32'h0A0B_0C0D);
      @(negedge clk);
      drive(0, 1, BASE + 4, 32'h0, 3'b010);
      #1 expectEq("cnt_after_rst", rdata, cycModel[31:0]);
      @(negedge clk);
      drive(0, 0, 32'h0, 32'h0, 3'b000);

      // Final report.
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
